// File: rtl/alu_result_stage.sv
// ALU result stage: captures adder/subtractor output, derives N/Z/C/V flags, buffers
// results in a two-entry skid buffer toward writeback and commits flags in retire order.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DESTW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] R3,
  input  logic             carryOut,
  input  logic             opSub,
  input  logic             aSign,
  input  logic             bSign,
  input  logic             setFlags,
  input  logic [DESTW-1:0] destIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [DESTW-1:0] destOut,
  output logic [3:0]       flagsOut,
  output logic [3:0]       flagsQ
);

  // Occupancy encodings
  localparam logic [1:0] CntEmpty = 2'd0;
  localparam logic [1:0] CntOne   = 2'd1;
  localparam logic [1:0] CntFull  = 2'd2;

  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_head_result;
  logic [DESTW-1:0] r_head_dest;
  logic [3:0]       r_head_flags;
  logic             r_head_setf;
  logic [WIDTH-1:0] r_skid_result;
  logic [DESTW-1:0] r_skid_dest;
  logic [3:0]       r_skid_flags;
  logic             r_skid_setf;
  logic [3:0]       r_flags_q;

  logic             w_accept;
  logic             w_retire;
  logic             w_n;
  logic             w_z;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_in_flags;

  logic [1:0]       w_count_next;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;

  assign w_accept = inValid && r_in_ready;
  assign w_retire = r_out_valid && outReady;

  // Condition flags from the raw adder output; sub carry means "no borrow"
  always_comb begin
    w_n = R3[WIDTH-1];
    w_z = (R3 == '0);
    w_c = carryOut;
    if (opSub) begin
      w_v = (aSign != bSign) && (R3[WIDTH-1] != aSign);
    end else begin
      w_v = (aSign == bSign) && (R3[WIDTH-1] != aSign);
    end
    w_in_flags = {w_n, w_z, w_c, w_v};
  end

  // Occupancy transitions and which storage register loads this cycle
  always_comb begin
    w_count_next     = r_count;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_count)
      CntEmpty: begin
        if (w_accept) begin
          w_load_head_in = 1'b1;
          w_count_next   = CntOne;
        end
      end
      CntOne: begin
        if (w_accept && w_retire) begin
          w_load_head_in = 1'b1;
        end else if (w_accept) begin
          w_load_skid  = 1'b1;
          w_count_next = CntFull;
        end else if (w_retire) begin
          w_count_next = CntEmpty;
        end
      end
      CntFull: begin
        // inReady is low here, so only a retire can happen
        if (w_retire) begin
          w_load_head_skid = 1'b1;
          w_count_next     = CntOne;
        end
      end
      default: begin
        w_count_next = CntEmpty;
      end
    endcase
  end

  // State update: occupancy, handshake flags, head/skid storage and committed flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= CntEmpty;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_head_result <= '0;
      r_head_dest   <= '0;
      r_head_flags  <= 4'b0000;
      r_head_setf   <= 1'b0;
      r_skid_result <= '0;
      r_skid_dest   <= '0;
      r_skid_flags  <= 4'b0000;
      r_skid_setf   <= 1'b0;
      r_flags_q     <= 4'b0000;
    end else begin
      r_count     <= w_count_next;
      r_in_ready  <= (w_count_next != CntFull);
      r_out_valid <= (w_count_next != CntEmpty);
      if (w_load_head_in) begin
        r_head_result <= R3;
        r_head_dest   <= destIn;
        r_head_flags  <= w_in_flags;
        r_head_setf   <= setFlags;
      end else if (w_load_head_skid) begin
        r_head_result <= r_skid_result;
        r_head_dest   <= r_skid_dest;
        r_head_flags  <= r_skid_flags;
        r_head_setf   <= r_skid_setf;
      end
      if (w_load_skid) begin
        r_skid_result <= R3;
        r_skid_dest   <= destIn;
        r_skid_flags  <= w_in_flags;
        r_skid_setf   <= setFlags;
      end
      // The retiring entry is always the current head
      if (w_retire && r_head_setf) begin
        r_flags_q <= r_head_flags;
      end
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign result   = r_head_result;
  assign destOut  = r_head_dest;
  assign flagsOut = r_head_flags;
  assign flagsQ   = r_flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DESTW = 5;

  logic             clk;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] R3;
  logic             carryOut;
  logic             opSub;
  logic             aSign;
  logic             bSign;
  logic             setFlags;
  logic [DESTW-1:0] destIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic [DESTW-1:0] destOut;
  logic [3:0]       flagsOut;
  logic [3:0]       flagsQ;

  int total;
  int bad;

  alu_result_stage #(
    .WIDTH(WIDTH),
    .DESTW(DESTW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .R3       (R3),
    .carryOut (carryOut),
    .opSub    (opSub),
    .aSign    (aSign),
    .bSign    (bSign),
    .setFlags (setFlags),
    .destIn   (destIn),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .destOut  (destOut),
    .flagsOut (flagsOut),
    .flagsQ   (flagsQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] r, input logic c, input logic sub,
                      input logic as, input logic bs, input logic sf,
                      input logic [DESTW-1:0] d);
    R3       = r;
    carryOut = c;
    opSub    = sub;
    aSign    = as;
    bSign    = bs;
    setFlags = sf;
    destIn   = d;
    inValid  = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    R3       = '0;
    carryOut = 1'b0;
    opSub    = 1'b0;
    aSign    = 1'b0;
    bSign    = 1'b0;
    setFlags = 1'b0;
    destIn   = '0;

    // Reset state
    tick();
    tick();
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_inReady", 64'(inReady), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_destOut", 64'(destOut), 64'd0);
    check("rst_flagsOut", 64'(flagsOut), 64'd0);
    check("rst_flagsQ", 64'(flagsQ), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_inReady", 64'(inReady), 64'd1);

    // Sub with zero result: N0 Z1 C1 V0
    outReady = 1'b1;
    push(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    inValid = 1'b0;
    check("sub0_outValid", 64'(outValid), 64'd1);
    check("sub0_flagsOut", 64'(flagsOut), 64'h6);
    check("sub0_destOut", 64'(destOut), 64'd3);
    check("sub0_flagsQ_pre", 64'(flagsQ), 64'd0);
    tick();
    check("sub0_outValid_after", 64'(outValid), 64'd0);
    check("sub0_flagsQ", 64'(flagsQ), 64'h6);

    // Sub overflow: N1 Z0 C0 V1, held by backpressure
    outReady = 1'b0;
    push(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
    tick();
    inValid = 1'b0;
    check("subovf_flagsOut", 64'(flagsOut), 64'h9);
    check("subovf_result", 64'(result), 64'h8000_0000);
    outReady = 1'b1;
    tick();
    check("subovf_flagsQ_nocommit", 64'(flagsQ), 64'h6);

    // Add overflow: N0 Z0 C1 V1, committed
    push(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5);
    tick();
    inValid = 1'b0;
    check("addovf_flagsOut", 64'(flagsOut), 64'h3);
    tick();
    check("addovf_flagsQ", 64'(flagsQ), 64'h3);

    // Backpressure: A, B fill the buffer, C is held off until space frees
    outReady = 1'b0;
    push(32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    tick();
    check("bp_A_result", 64'(result), 64'hA);
    check("bp_A_inReady", 64'(inReady), 64'd1);
    push(32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
    tick();
    check("bp_full_inReady", 64'(inReady), 64'd0);
    check("bp_full_result", 64'(result), 64'hA);
    push(32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    tick();
    check("bp_C_held_inReady", 64'(inReady), 64'd0);
    check("bp_C_held_result", 64'(result), 64'hA);
    outReady = 1'b1;
    tick();
    check("bp_B_result", 64'(result), 64'hB);
    check("bp_B_destOut", 64'(destOut), 64'd2);
    check("bp_B_inReady", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
    check("bp_C_result", 64'(result), 64'hC);
    check("bp_C_outValid", 64'(outValid), 64'd1);
    tick();
    check("bp_drained", 64'(outValid), 64'd0);

    // Streaming 1..10 with outReady held high
    outReady = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push(WIDTH'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DESTW'(i));
      tick();
      check("stream_result", 64'(result), 64'(i));
      check("stream_inReady", 64'(inReady), 64'd1);
      check("stream_outValid", 64'(outValid), 64'd1);
    end
    inValid = 1'b0;
    tick();
    check("stream_drained", 64'(outValid), 64'd0);

    // Flag masking: commit 0110, then retire a 1000 entry without setFlags
    push(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    push(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
    tick();
    inValid = 1'b0;
    check("mask_flagsQ_commit", 64'(flagsQ), 64'h6);
    check("mask_flagsOut", 64'(flagsOut), 64'h8);
    tick();
    check("mask_flagsQ_held", 64'(flagsQ), 64'h6);
    check("mask_outValid", 64'(outValid), 64'd0);

    // Reset while full
    outReady = 1'b0;
    push(32'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
    tick();
    push(32'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    check("rstmid_full_inReady", 64'(inReady), 64'd0);
    reset    = 1'b1;
    outReady = 1'b1;
    tick();
    check("rstmid_outValid", 64'(outValid), 64'd0);
    check("rstmid_flagsQ", 64'(flagsQ), 64'd0);
    check("rstmid_inReady", 64'(inReady), 64'd0);
    check("rstmid_result", 64'(result), 64'd0);
    reset   = 1'b0;
    inValid = 1'b0;
    tick();
    check("rstmid_inReady_after", 64'(inReady), 64'd1);
    check("rstmid_no_stale", 64'(outValid), 64'd0);
    tick();
    check("rstmid_no_stale2", 64'(outValid), 64'd0);
    check("rstmid_flagsQ_after", 64'(flagsQ), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
